// File: rtl/rps_pkg.sv
// Shared constants, state encoding and the round-judging rule for the rock-paper-scissors
// round sequencer.
package rps_pkg;

  localparam logic [2:0] ROCK     = 3'b100;
  localparam logic [2:0] PAPER    = 3'b010;
  localparam logic [2:0] SCISSORS = 3'b001;

  localparam logic [1:0] RES_TIE  = 2'b00;
  localparam logic [1:0] RES_COMP = 2'b01;
  localparam logic [1:0] RES_USER = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_MOVE = 3'd1,
    JUDGE     = 3'd2,
    SHOW      = 3'd3,
    DONE      = 3'd4
  } state_e;

  function automatic logic is_move(input logic [2:0] m);
    return (m == ROCK) || (m == PAPER) || (m == SCISSORS);
  endfunction

  // Residue 0/1/2 of the LFSR value picks rock/paper/scissors.
  function automatic logic [2:0] move_from_lfsr(input logic [7:0] v);
    logic [7:0] r;
    r = v % 8'd3;
    case (r)
      8'd0:    return ROCK;
      8'd1:    return PAPER;
      default: return SCISSORS;
    endcase
  endfunction

  function automatic logic [1:0] judge(input logic [2:0] user, input logic [2:0] comp);
    if (user == comp) begin
      return RES_TIE;
    end
    if ((user == ROCK && comp == SCISSORS) || (user == PAPER && comp == ROCK) ||
        (user == SCISSORS && comp == PAPER)) begin
      return RES_USER;
    end
    return RES_COMP;
  endfunction

endpackage

// File: rtl/rps_tick_gen.sv
// Free-running divider producing a single-cycle enable pulse every TICK_DIV clock cycles.
module rps_tick_gen #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round sequencer: arms on start, judges one move against an LFSR draw,
// keeps saturating scores and declares the match. Optional move timeout: RPS_MOVE_TIMEOUT_EN.
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 25000000,
  parameter int unsigned SHOW_TICKS    = 4,
  parameter int unsigned WIN_SCORE     = 7,
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [2:0] user_move,
  input  logic       user_valid,
  output logic [2:0] comp_move,
  output logic [1:0] result,
  output logic [2:0] user_score,
  output logic [2:0] comp_score,
  output logic       beep,
  output logic       match_over,
  output logic       winner,
  output logic       busy
);

  if (TICK_DIV < 2 || SHOW_TICKS < 1 || WIN_SCORE < 1 || WIN_SCORE > 7 ||
      TIMEOUT_TICKS < 1) begin : g_param_check
    $error("rps_round_ctrl: illegal parameter value");
  end

  localparam logic [2:0] WinScore = 3'(WIN_SCORE);
  localparam int unsigned ShowW = $clog2(SHOW_TICKS + 1);
  localparam logic [ShowW-1:0] ShowLast = ShowW'(SHOW_TICKS - 1);

  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    return (s < WinScore) ? s + 3'd1 : s;
  endfunction

  logic tick;

  rps_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (tick)
  );

  state_e           state_q, state_d;
  logic             start_q;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [2:0]       user_move_q, user_move_d;
  logic [2:0]       comp_move_q, comp_move_d;
  logic [1:0]       result_q, result_d;
  logic [2:0]       user_score_q, user_score_d;
  logic [2:0]       comp_score_q, comp_score_d;
  logic             match_over_q, match_over_d;
  logic             winner_q, winner_d;
  logic [ShowW-1:0] show_cnt_q, show_cnt_d;
  logic             start_rise;
  logic             move_ok;

`ifdef RPS_MOVE_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_TICKS - 1);
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  assign start_rise = start && !start_q;
  assign move_ok    = user_valid && is_move(user_move);

  // x^8+x^6+x^5+x^4+1; a nonzero seed keeps it off the all-zero lockup state.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d      = state_q;
    user_move_d  = user_move_q;
    comp_move_d  = comp_move_q;
    result_d     = result_q;
    user_score_d = user_score_q;
    comp_score_d = comp_score_q;
    match_over_d = match_over_q;
    winner_d     = winner_q;
    show_cnt_d   = show_cnt_q;
`ifdef RPS_MOVE_TIMEOUT_EN
    wait_cnt_d   = (state_q == WAIT_MOVE) ? wait_cnt_q : '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = WAIT_MOVE;
        end
      end
      WAIT_MOVE: begin
        if (move_ok) begin
          user_move_d = user_move;
          comp_move_d = move_from_lfsr(lfsr_q);
          state_d     = JUDGE;
        end
`ifdef RPS_MOVE_TIMEOUT_EN
        else if (tick) begin
          if (wait_cnt_q == WaitLast) begin
            comp_move_d  = '0;
            result_d     = RES_COMP;
            comp_score_d = sat_inc(comp_score_q);
            show_cnt_d   = '0;
            state_d      = SHOW;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end
`endif
      end
      JUDGE: begin
        result_d = judge(user_move_q, comp_move_q);
        if (result_d == RES_USER) begin
          user_score_d = sat_inc(user_score_q);
        end else if (result_d == RES_COMP) begin
          comp_score_d = sat_inc(comp_score_q);
        end
        show_cnt_d = '0;
        state_d    = SHOW;
      end
      SHOW: begin
        if (tick) begin
          if (show_cnt_q == ShowLast) begin
            if (user_score_q == WinScore || comp_score_q == WinScore) begin
              match_over_d = 1'b1;
              winner_d     = (user_score_q == WinScore);
              state_d      = DONE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            show_cnt_d = show_cnt_q + ShowW'(1);
          end
        end
      end
      DONE: begin
        if (start_rise) begin
          user_score_d = '0;
          comp_score_d = '0;
          result_d     = RES_TIE;
          comp_move_d  = '0;
          match_over_d = 1'b0;
          winner_d     = 1'b0;
          state_d      = WAIT_MOVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      lfsr_q       <= 8'h01;
      user_move_q  <= '0;
      comp_move_q  <= '0;
      result_q     <= RES_TIE;
      user_score_q <= '0;
      comp_score_q <= '0;
      match_over_q <= 1'b0;
      winner_q     <= 1'b0;
      show_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      lfsr_q       <= lfsr_d;
      user_move_q  <= user_move_d;
      comp_move_q  <= comp_move_d;
      result_q     <= result_d;
      user_score_q <= user_score_d;
      comp_score_q <= comp_score_d;
      match_over_q <= match_over_d;
      winner_q     <= winner_d;
      show_cnt_q   <= show_cnt_d;
    end
  end

`ifdef RPS_MOVE_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign comp_move  = comp_move_q;
  assign result     = result_q;
  assign user_score = user_score_q;
  assign comp_score = comp_score_q;
  assign match_over = match_over_q;
  assign winner     = winner_q;
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign beep       = (state_q == SHOW) && (result_q == RES_USER);

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Randomized self-checking bench for rps_round_ctrl against a round-level game model.
module tb_rps_round_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned ST = 2;
  localparam int unsigned WS = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic [2:0] user_move = 3'b000;
  logic       user_valid = 1'b0;
  logic [2:0] comp_move;
  logic [1:0] result;
  logic [2:0] user_score;
  logic [2:0] comp_score;
  logic       beep;
  logic       match_over;
  logic       winner;
  logic       busy;

  rps_round_ctrl #(
    .TICK_DIV      (TD),
    .SHOW_TICKS    (ST),
    .WIN_SCORE     (WS),
    .TIMEOUT_TICKS (3)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .user_move  (user_move),
    .user_valid (user_valid),
    .comp_move  (comp_move),
    .result     (result),
    .user_score (user_score),
    .comp_score (comp_score),
    .beep       (beep),
    .match_over (match_over),
    .winner     (winner),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Cycle count since reset release and the spec's LFSR value.
  int unsigned cyc;
  logic [7:0]  lfsr_m;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc    <= 0;
      lfsr_m <= 8'h01;
    end else begin
      cyc    <= cyc + 1;
      lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
    end
  end

  logic [2:0] mv_tab [3] = '{3'b100, 3'b010, 3'b001};

  int         m_us = 0;
  int         m_cs = 0;
  int         m_res = 0;
  logic [2:0] m_cm = 3'b000;
  bit         m_done = 1'b0;
  bit         m_win = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_comp_move"}, 32'(comp_move), 32'(m_cm));
    check_val({tag, "_result"}, 32'(result), 32'(m_res));
    check_val({tag, "_user_score"}, 32'(user_score), 32'(m_us));
    check_val({tag, "_comp_score"}, 32'(comp_score), 32'(m_cs));
    check_val({tag, "_match_over"}, 32'(match_over), 32'(m_done));
    check_val({tag, "_winner"}, 32'(winner), 32'(m_win));
  endtask

  function automatic int idx_of(input logic [2:0] mv);
    for (int i = 0; i < 3; i++) begin
      if (mv_tab[i] == mv) return i;
    end
    return 0;
  endfunction

  // One full round from IDLE/DONE; optionally a junk strobe first, busy pokes, or a reset in SHOW.
  task automatic play_round(input logic [2:0] mv, input int want, input bit bad_first,
                            input bit poke, input bit abort);
    int          cidx;
    int          uidx;
    int          d;
    int          k;
    int          n;
    int          nb;
    int          nbeep;
    int unsigned c;
    bit          found;
    logic [2:0]  junk;
    if (m_done) begin
      m_us = 0; m_cs = 0; m_res = 0; m_cm = 3'b000; m_done = 0; m_win = 0;
    end
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check_val("armed_busy", 32'(busy), 1);
    check_outputs("armed");
    if (bad_first) begin
      junk = (($urandom_range(0, 1) == 0) ? 3'b011 : 3'b000);
      user_move  = junk;
      user_valid = 1'b1;
      @(negedge CLK);
      user_valid = 1'b0;
      check_val("bad_move_busy", 32'(busy), 1);
      @(negedge CLK);
      check_outputs("bad_move_ignored");
    end
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (int'(lfsr_m % 8'd3) == want) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check_val("lfsr_reach", 32'(found), 1);
    cidx       = int'(lfsr_m % 8'd3);
    user_move  = mv;
    user_valid = 1'b1;
    @(negedge CLK);
    user_valid = 1'b0;
    user_move  = 3'b111;
    if (poke) start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    // Now in SHOW: apply the game rules.
    uidx = idx_of(mv);
    d    = (uidx - cidx + 3) % 3;
    m_res = (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    m_cm  = mv_tab[cidx];
    if (m_res == 2 && m_us < WS) m_us++;
    if (m_res == 1 && m_cs < WS) m_cs++;
    check_outputs("judged");
    if (abort) begin
      #2 RST_N = 1'b0;
      #1;
      m_us = 0; m_cs = 0; m_res = 0; m_cm = 3'b000; m_done = 0; m_win = 0;
      check_outputs("abort");
      check_val("abort_busy", 32'(busy), 0);
      check_val("abort_beep", 32'(beep), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      return;
    end
    c = cyc; k = 0; n = 0;
    while (k < int'(ST)) begin
      if (c % TD == TD - 1) k++;
      n++;
      c++;
    end
    nb = 0; nbeep = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      nb++;
      if (beep) nbeep++;
      if (poke && i == 0) begin
        user_valid = 1'b1;
        user_move  = 3'b100;
        start      = 1'b1;
      end else begin
        user_valid = 1'b0;
        start      = 1'b0;
      end
      @(negedge CLK);
    end
    user_valid = 1'b0;
    start      = 1'b0;
    check_val("show_cycles", 32'(nb), 32'(n));
    check_val("beep_cycles", 32'(nbeep), 32'((m_res == 2) ? n : 0));
    m_done = (m_us == WS) || (m_cs == WS);
    m_win  = m_done && (m_us == WS);
    check_val("after_show_busy", 32'(busy), 0);
    check_val("after_show_beep", 32'(beep), 0);
    check_outputs("after_show");
  endtask

  task automatic done_poke();
    user_move  = 3'b010;
    user_valid = 1'b1;
    @(negedge CLK);
    user_valid = 1'b0;
    @(negedge CLK);
    check_val("done_busy", 32'(busy), 0);
    check_outputs("done_frozen");
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check_outputs("reset");
    check_val("reset_busy", 32'(busy), 0);
    check_val("reset_beep", 32'(beep), 0);
    RST_N = 1'b1;
    @(negedge CLK);
    play_round(3'b100, 2, 1'b0, 1'b0, 1'b0);
    play_round(3'b010, 1, 1'b0, 1'b0, 1'b0);
    play_round(3'b001, 0, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 40 && !m_done; r++) begin
      play_round(mv_tab[$urandom_range(0, 2)], int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    done_poke();
    for (int r = 0; r < 3; r++) begin
      play_round(3'b100, 2, 1'b0, (r == 1), 1'b0);
    end
    check_val("three_wins_match_over", 32'(match_over), 1);
    check_val("three_wins_winner", 32'(winner), 1);
    check_val("three_wins_user_score", 32'(user_score), 32'(WS));
    done_poke();
    play_round(3'b010, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    check_outputs("post_reset");
    check_val("post_reset_busy", 32'(busy), 0);
    play_round(3'b001, 1, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
